ac_seq: RTL
===========

# ac_seq

Micro-operation sequencer that drives the accumulator's load/publish/clear strobes and the data-memory strobes for one instruction at a time. It accepts a 10-bit instruction over a valid/ready handshake and steps through a fixed per-opcode strobe sequence. It returns a one-cycle done pulse and sits between instruction fetch and the AC/memory/ALU datapath on the shared 10-bit bus.

## Interface
- WIDTH, 10: instruction and bus word width; opcode is [WIDTH-1:WIDTH-4], address is [WIDTH-5:0].
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- instr  in  WIDTH  instruction word, sampled on accept.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  high only in IDLE; accept = instr_valid & instr_ready.
- mem_addr  out  WIDTH-4  latched address field, held until next accept.
- mem_re  out  1  memory drives bus next cycle.
- mem_we  out  1  memory captures bus this edge.
- ac_re  out  1  AC captures bus into its store.
- ac_we  out  1  AC publishes store to its output.
- ac_clear  out  1  AC output forced to zero.
- alu_en  out  1  ALU computes AC + bus.
- bus_sel  out  1  0 = memory/AC on bus, 1 = ALU result on bus.
- done  out  1  one-cycle pulse, instruction complete.
- err  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 CLA, 4 ADD, 5 OUT; 6–15 illegal.
- States: IDLE, RUN (2-bit step counter 0..3), ERR.
- IDLE: instr_ready=1. On accept, latch opcode and address, step=0, go to RUN.
- RUN strobe sequences, one line per step (unlisted strobes are 0):
  - NOP: step0 none.
  - CLA: step0 ac_clear.
  - OUT: step0 ac_we.
  - STA: step0 ac_we; step1 mem_we.
  - LDA: step0 mem_re; step1 ac_re; step2 ac_we.
  - ADD: step0 mem_re; step1 alu_en; step2 ac_re + bus_sel; step3 ac_we.
- Leaving the last step sets state to IDLE and registers done=1 for exactly one cycle.
- Strobes are decoded only from registered state/opcode/step, so they carry no combinational path from instr or instr_valid.
- Exactly one datapath strobe group is active per cycle. ac_clear never coincides with ac_we or ac_re.
- Illegal opcode on accept: behaviour set by Configuration.
- rst in any state: IDLE, step=0, all strobes 0, done=0, err=0, mem_addr=0. An in-flight instruction is abandoned with no done.

## Timing
- Accept at edge T. First strobe cycle is T+1. N strobe cycles: NOP/CLA/OUT 1, STA 2, LDA 3, ADD 4.
- done is high in cycle T+N+1. instr_ready is high in the same cycle, so back-to-back accept is allowed there.
- instr_valid while not ready is ignored. instr may change freely outside the accept cycle.
- mem_re at step k: the bus holds memory data at step k+1, and ac_re/alu_en sample it there.
- Reset values: instr_ready=1 (after reset, in IDLE); every other output 0.

## Configuration
- ACSEQ_ILLEGAL_TRAP_EN defined:
  - An illegal opcode on accept enters ERR with err=1 and instr_ready=0. No strobes and no done are issued.
  - Only rst leaves ERR.
- Not defined:
  - An illegal opcode executes as NOP (1 cycle, done pulses).
  - err is tied 0 and the ERR state is not built.

## Structure
- Shared package acseq_pkg holds the opcode constants (OP_NOP … OP_OUT), the state encoding, and the per-opcode strobe-cycle counts.
- One sub-module, acseq_decode: combinational (opcode, step) → strobe vector plus last_step flag.
- The top level holds the FSM, step counter, latches, and done register.

## Test plan
- Reset then CLA (instr=0x0C0): ac_clear high at T+1 only; done at T+2; err=0.
- LDA addr 0x15 (0x055): mem_addr=0x15 from T+1. Then mem_re T+1, ac_re T+2, ac_we T+3, done T+4.
- ADD back-to-back with STA, accepting STA in ADD's done cycle: ADD strobes at T+1..T+4 with bus_sel only at T+3. STA accepted at T+5, ac_we T+6, mem_we T+7, done T+8.
- rst asserted during LDA step1: next cycle all strobes 0, instr_ready=1, no done pulse.
- Opcode 0xF with ACSEQ_ILLEGAL_TRAP_EN: err=1 and instr_ready=0 persist for 20 cycles with instr_valid high; rst clears both.
- Opcode 0xF without the macro: NOP behaviour, done at T+2, err=0.

Source files
------------

// File: rtl/acseq_pkg.sv
// acseq_pkg
// Shared definitions for the accumulator micro-operation sequencer:
//   - opcode constants OP_NOP .. OP_OUT (6..15 are illegal)
//   - FSM state encoding (IDLE, RUN, ERR)
//   - strobe vector bit positions used between acseq_decode and ac_seq
//   - per-opcode strobe-cycle counts and a legality helper
package acseq_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_STA = 4'd2;
   localparam logic [3:0] OP_CLA = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_OUT = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   localparam int NUM_STROBES = 7;
   localparam int S_MEM_RE    = 0;
   localparam int S_MEM_WE    = 1;
   localparam int S_AC_RE     = 2;
   localparam int S_AC_WE     = 3;
   localparam int S_AC_CLEAR  = 4;
   localparam int S_ALU_EN    = 5;
   localparam int S_BUS_SEL   = 6;

   // Number of strobe cycles each opcode occupies in RUN. Illegal opcodes
   // fall into the default and therefore behave like a one-cycle NOP.
   function automatic logic [2:0] op_cycles(input logic [3:0] op);
      case (op)
         OP_STA:  return 3'd2;
         OP_LDA:  return 3'd3;
         OP_ADD:  return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      return (op <= OP_OUT);
   endfunction

endpackage

// File: rtl/acseq_decode.sv
// acseq_decode
// Purely combinational decode of (opcode, step) into the datapath strobe
// vector and a flag marking the final step of the instruction.
// Ports:
//   en         in   1            strobes are only produced while running
//   opcode     in   4            latched opcode
//   step       in   2            current step counter
//   strobes    out  NUM_STROBES  indexed by the S_* positions in acseq_pkg
//   last_step  out  1            current step is the opcode's final one
module acseq_decode
   import acseq_pkg::*;
(
   input  logic                   en,
   input  logic [3:0]             opcode,
   input  logic [1:0]             step,
   output logic [NUM_STROBES-1:0] strobes,
   output logic                   last_step
);

   // Each opcode/step pair asserts one strobe group; anything not listed,
   // including every illegal opcode, leaves the vector at zero.
   always_comb begin
      strobes   = '0;
      last_step = ({1'b0, step} == (op_cycles(opcode) - 3'd1));
      if (en) begin
         case (opcode)
            OP_CLA: if (step == 2'd0) strobes[S_AC_CLEAR] = 1'b1;
            OP_OUT: if (step == 2'd0) strobes[S_AC_WE] = 1'b1;
            OP_STA: begin
               case (step)
                  2'd0:    strobes[S_AC_WE] = 1'b1;
                  2'd1:    strobes[S_MEM_WE] = 1'b1;
                  default: ;
               endcase
            end
            OP_LDA: begin
               case (step)
                  2'd0:    strobes[S_MEM_RE] = 1'b1;
                  2'd1:    strobes[S_AC_RE] = 1'b1;
                  2'd2:    strobes[S_AC_WE] = 1'b1;
                  default: ;
               endcase
            end
            OP_ADD: begin
               case (step)
                  2'd0: strobes[S_MEM_RE] = 1'b1;
                  2'd1: strobes[S_ALU_EN] = 1'b1;
                  2'd2: begin
                     strobes[S_AC_RE]   = 1'b1;
                     strobes[S_BUS_SEL] = 1'b1;
                  end
                  default: strobes[S_AC_WE] = 1'b1;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ac_seq.sv
// ac_seq
// Micro-operation sequencer: accepts one instruction over valid/ready,
// steps through the per-opcode strobe sequence and pulses done once.
// Optional feature macro: ACSEQ_ILLEGAL_TRAP_EN (illegal opcodes trap into
// a sticky ERR state instead of running as NOP).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr, instr_valid  instruction word and its valid
//   instr_ready         high only in IDLE
//   mem_addr            address field latched on accept
//   mem_re, mem_we      data-memory strobes
//   ac_re, ac_we        AC capture / publish strobes
//   ac_clear            AC output clear
//   alu_en, bus_sel     ALU compute and bus source select
//   done                one-cycle completion pulse
//   err                 sticky illegal-opcode flag (0 without the macro)
module ac_seq
   import acseq_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [WIDTH-5:0] mem_addr,
   output logic             mem_re,
   output logic             mem_we,
   output logic             ac_re,
   output logic             ac_we,
   output logic             ac_clear,
   output logic             alu_en,
   output logic             bus_sel,
   output logic             done,
   output logic             err
);

   state_t                   state, state_next;
   logic [1:0]               step, step_next;
   logic [3:0]               opcode;
   logic                     done_next;
   logic                     accept;
   logic                     last_step;
   logic [NUM_STROBES-1:0]   strobes;

   assign instr_ready = (state == ST_IDLE);
   assign accept      = instr_valid & instr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         step     <= 2'd0;
         opcode   <= OP_NOP;
         mem_addr <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_next;
         step  <= step_next;
         done  <= done_next;
         if (accept) begin
            opcode   <= instr[WIDTH-1:WIDTH-4];
            mem_addr <= instr[WIDTH-5:0];
         end
      end
   end

   always_comb begin
      state_next = state;
      step_next  = step;
      done_next  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               step_next  = 2'd0;
               state_next = ST_RUN;
`ifdef ACSEQ_ILLEGAL_TRAP_EN
               if (!is_legal(instr[WIDTH-1:WIDTH-4])) state_next = ST_ERR;
`endif
            end
         end
         ST_RUN: begin
            if (last_step) begin
               state_next = ST_IDLE;
               step_next  = 2'd0;
               done_next  = 1'b1;
            end else begin
               step_next = step + 2'd1;
            end
         end
`ifdef ACSEQ_ILLEGAL_TRAP_EN
         ST_ERR: state_next = ST_ERR;
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   // Strobes come only from registered state/opcode/step, so nothing on
   // instr or instr_valid can reach them combinationally.
   acseq_decode u_decode (
      .en        (state == ST_RUN),
      .opcode    (opcode),
      .step      (step),
      .strobes   (strobes),
      .last_step (last_step)
   );

   assign mem_re   = strobes[S_MEM_RE];
   assign mem_we   = strobes[S_MEM_WE];
   assign ac_re    = strobes[S_AC_RE];
   assign ac_we    = strobes[S_AC_WE];
   assign ac_clear = strobes[S_AC_CLEAR];
   assign alu_en   = strobes[S_ALU_EN];
   assign bus_sel  = strobes[S_BUS_SEL];

`ifdef ACSEQ_ILLEGAL_TRAP_EN
   assign err = (state == ST_ERR);
`else
   assign err = 1'b0;
`endif

endmodule
